// File: rtl/arm_mem_pkg.sv
// Shared encodings for the ARM memory-access path: size codes, AHB-Lite
// transfer/size encodings, LSU state enum and small helper functions.
package arm_mem_pkg;

  // Decode-side access size (AHB_size)
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;

  // AHB-Lite HTRANS
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // AHB-Lite HSIZE
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_SWP_W
  } lsu_state_e;

  // Latched attributes of the op in flight
  typedef struct packed {
    logic       is_ld;   // plain load
    logic       is_swp;  // locked read-then-write
    logic       sext;    // sign-extend sub-word load data
    logic [1:0] size;
    logic [4:0] id;
  } lsu_op_t;

  function automatic logic [2:0] hsize_of(input logic [1:0] size);
    case (size)
      SZ_BYTE: hsize_of = HSIZE_BYTE;
      SZ_HALF: hsize_of = HSIZE_HALF;
      default: hsize_of = HSIZE_WORD;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = a[0];
      default: misaligned = |a;
    endcase
  endfunction

  // Sub-word stores are replicated so every byte lane carries the data
  function automatic logic [31:0] wdata_rep(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      SZ_BYTE: wdata_rep = {4{wd[7:0]}};
      SZ_HALF: wdata_rep = {2{wd[15:0]}};
      default: wdata_rep = wd;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword lane out of a 32-bit read beat and
// zero- or sign-extends it; word loads pass straight through.
module lsu_load_align
  import arm_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sext,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select and extension
  always_comb begin
    byte_v = rdata[{addr, 3'b000} +: 8];
    half_v = addr[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: data = {{24{sext & byte_v[7]}}, byte_v};
      SZ_HALF: data = {{16{sext & half_v[15]}}, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/ahb_lsu.sv
// Single-transfer AHB-Lite master load/store unit. One op in flight; the
// pipeline is stalled (busy) from the address phase until completion.
// SWP runs as a locked read followed by a write to the same address, with
// the read data written back only once the write has completed.
module ahb_lsu
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [1:0]        size,
  input  logic              ldr_p,
  input  logic              ldrs_s,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       base,
  input  logic [DATA_W-1:0] wdata,
  input  logic [4:0]        ld_id,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic              busy,
  output logic              wb_en,
  output logic [4:0]        wb_id,
  output logic [31:0]       wb_data,
  output logic              data_abort,
  output logic              align_fault
);

  lsu_state_e  state_q, state_d;
  lsu_op_t     op_q;
  logic [31:0] addr_q, wdata_q, rdata_q, eff_addr, ld_src, ld_data;
  logic [2:0]  hsize_q;
  logic        hwrite_q, lock_q, swp_wr_q;
  logic        take, fault, done, abort;

  assign eff_addr = ldr_p ? alu_result : base;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and per-cycle events
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    fault   = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // wr_en=rd_en=0 is accepted here and simply dropped
        if (req_valid && (wr_en || rd_en)) begin
          if (misaligned(size, eff_addr[1:0])) fault = 1'b1;
          else begin
            take    = 1'b1;
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR, ST_SWP_W: if (HREADY) state_d = ST_DATA;
      ST_DATA: begin
        if (HREADY) begin
          if (HRESP) begin
            // second cycle of the two-cycle ERROR response
            abort   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            done    = 1'b1;
            state_d = (op_q.is_swp && !swp_wr_q) ? ST_SWP_W : ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch and bus-side control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      hsize_q  <= HSIZE_BYTE;
      hwrite_q <= 1'b0;
      lock_q   <= 1'b0;
      swp_wr_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (take) begin
        op_q     <= '{is_ld: rd_en & ~wr_en, is_swp: rd_en & wr_en,
                      sext: ldrs_s, size: size, id: ld_id};
        addr_q   <= eff_addr;
        wdata_q  <= wdata_rep(size, wdata);
        hsize_q  <= hsize_of(size);
        hwrite_q <= wr_en & ~rd_en;
        lock_q   <= wr_en & rd_en;
        swp_wr_q <= 1'b0;
      end
      if (abort) lock_q <= 1'b0;
      if (done) begin
        if (op_q.is_swp && !swp_wr_q) begin
          // hold read data until the write half of the SWP finishes
          rdata_q  <= HRDATA;
          swp_wr_q <= 1'b1;
          hwrite_q <= 1'b1;
        end else begin
          lock_q <= 1'b0;
        end
      end
    end
  end

  // SWP writes back the captured read beat, loads the live bus beat
  assign ld_src = swp_wr_q ? rdata_q : HRDATA;

  lsu_load_align u_align (
    .rdata (ld_src),
    .addr  (addr_q[1:0]),
    .size  (op_q.size),
    .sext  (op_q.sext),
    .data  (ld_data)
  );

  // Write-back port and one-cycle fault strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en       <= 1'b0;
      wb_id       <= '0;
      wb_data     <= '0;
      data_abort  <= 1'b0;
      align_fault <= 1'b0;
    end else begin
      wb_en       <= 1'b0;
      data_abort  <= abort;
      align_fault <= fault;
      if (done && (op_q.is_ld || (op_q.is_swp && swp_wr_q))) begin
        wb_en   <= 1'b1;
        wb_id   <= op_q.id;
        wb_data <= ld_data;
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = ~req_ready;
  assign HTRANS    = (state_q == ST_ADDR || state_q == ST_SWP_W) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = addr_q[ADDR_W-1:0];
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = lock_q;
  assign HWDATA    = wdata_q;

endmodule

// File: tb/tb_ahb_lsu.sv
// Directed bench for ahb_lsu. Inputs change 1 time unit after the rising
// edge and outputs are sampled there too, so each sample describes the
// cycle that just started.
module tb_ahb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic        wr_en = 1'b0, rd_en = 1'b0, ldr_p = 1'b0, ldrs_s = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] alu_result = '0, base = '0, wdata = '0;
  logic [4:0]  ld_id = '0;
  logic [31:0] HADDR, HWDATA, HRDATA = '0, wb_data;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY = 1'b1, HRESP = 1'b0;
  logic [2:0]  HSIZE, HBURST;
  logic        busy, wb_en, data_abort, align_fault;
  logic [4:0]  wb_id;

  int errors = 0;
  int checks = 0;

  ahb_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .wr_en(wr_en), .rd_en(rd_en), .size(size), .ldr_p(ldr_p), .ldrs_s(ldrs_s),
    .alu_result(alu_result), .base(base), .wdata(wdata), .ld_id(ld_id),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP), .busy(busy), .wb_en(wb_en), .wb_id(wb_id),
    .wb_data(wb_data), .data_abort(data_abort), .align_fault(align_fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle; returns in cycle T+1
  task automatic issue(input logic w, r, input logic [1:0] sz, input logic p, s,
                       input logic [31:0] alu, b, wd, input logic [4:0] id);
    wr_en = w; rd_en = r; size = sz; ldr_p = p; ldrs_s = s;
    alu_result = alu; base = b; wdata = wd; ld_id = id; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({HTRANS, HWRITE, HMASTLOCK, HSIZE, HBURST, wb_en, wb_id, data_abort, align_fault, req_ready, busy} !==
        {2'b00, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_ctrl: HTRANS=%b HWRITE=%b LOCK=%b HSIZE=%b wb_en=%b wb_id=%0d abort=%b afault=%b ready=%b busy=%b",
        HTRANS, HWRITE, HMASTLOCK, HSIZE, wb_en, wb_id, data_abort, align_fault, req_ready, busy);
    end
    checks++;
    if ({HADDR, HWDATA, wb_data} !== 96'h0) begin
      errors++; $display("FAIL reset_data: HADDR=%h HWDATA=%h wb_data=%h, want all 0", HADDR, HWDATA, wb_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ldr_word();
    HRDATA = 32'hDEADBEEF;
    issue(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h1000, 32'h5555_0000, 32'h0, 5'd7);
    checks++;
    if ({HTRANS, HWRITE, HSIZE, HMASTLOCK, busy, HADDR} !== {2'b10, 1'b0, 3'b010, 1'b0, 1'b1, 32'h1000}) begin
      errors++; $display("FAIL ldr_addr: HTRANS=%b HWRITE=%b HSIZE=%b LOCK=%b busy=%b HADDR=%h, want 10 0 010 0 1 00001000",
        HTRANS, HWRITE, HSIZE, HMASTLOCK, busy, HADDR);
    end
    tick();
    checks++;
    if ({HTRANS, wb_en, busy} !== {2'b00, 1'b0, 1'b1}) begin
      errors++; $display("FAIL ldr_data: HTRANS=%b wb_en=%b busy=%b, want 00 0 1", HTRANS, wb_en, busy);
    end
    tick();
    checks++;
    if ({wb_en, wb_id, wb_data, req_ready} !== {1'b1, 5'd7, 32'hDEADBEEF, 1'b1}) begin
      errors++; $display("FAIL ldr_wb: wb_en=%b id=%0d data=%h ready=%b, want 1 7 deadbeef 1", wb_en, wb_id, wb_data, req_ready);
    end
    tick();
    checks++;
    if (wb_en !== 1'b0) begin
      errors++; $display("FAIL ldr_wb_pulse: wb_en=%b, want 0", wb_en);
    end
  endtask

  task automatic test_ldrb_ext();
    logic [31:0] exp [2];
    exp[0] = 32'h0000_0080;
    exp[1] = 32'hFFFF_FF80;
    HRDATA = 32'h80FF_0000;
    for (int s = 0; s < 2; s++) begin
      issue(1'b0, 1'b1, 2'b11, 1'b1, s[0], 32'h2003, 32'h0, 32'h0, 5'd3);
      checks++;
      if ({HSIZE, HADDR} !== {3'b000, 32'h2003}) begin
        errors++; $display("FAIL ldrb_addr s=%0d: HSIZE=%b HADDR=%h, want 000 00002003", s, HSIZE, HADDR);
      end
      tick(); tick();
      checks++;
      if ({wb_en, wb_data} !== {1'b1, exp[s]}) begin
        errors++; $display("FAIL ldrb_ext s=%0d: wb_en=%b data=%h, want 1 %h", s, wb_en, wb_data, exp[s]);
      end
    end
  endtask

  task automatic test_strh_wait();
    int  nbusy = 0;
    logic saw_wb = 1'b0;
    issue(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h9999_0000, 32'h3002, 32'h1234ABCD, 5'd1);
    checks++;
    if ({HTRANS, HWRITE, HSIZE, HADDR} !== {2'b10, 1'b1, 3'b001, 32'h3002}) begin
      errors++; $display("FAIL strh_addr: HTRANS=%b HWRITE=%b HSIZE=%b HADDR=%h, want 10 1 001 00003002", HTRANS, HWRITE, HSIZE, HADDR);
    end
    // c=0 ADDR, c=1..2 DATA wait states, c=3 DATA completes, then idle
    for (int c = 0; c < 6; c++) begin
      HREADY = (c == 1 || c == 2) ? 1'b0 : 1'b1;
      nbusy += int'(busy);
      saw_wb |= wb_en;
      if (c == 2) begin
        checks++;
        if (HWDATA !== 32'hABCDABCD) begin
          errors++; $display("FAIL strh_hwdata: HWDATA=%h, want abcdabcd", HWDATA);
        end
      end
      tick();
    end
    HREADY = 1'b1;
    checks++;
    if (nbusy !== 4) begin
      errors++; $display("FAIL strh_busy: busy cycles=%0d, want 4", nbusy);
    end
    checks++;
    if (saw_wb !== 1'b0) begin
      errors++; $display("FAIL strh_no_wb: wb_en seen during store");
    end
  endtask

  task automatic test_swp();
    HRDATA = 32'h11;
    issue(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 32'h4000, 32'h0, 32'h22, 5'd9);
    checks++;
    if ({HTRANS, HWRITE, HMASTLOCK, HADDR} !== {2'b10, 1'b0, 1'b1, 32'h4000}) begin
      errors++; $display("FAIL swp_rd_addr: HTRANS=%b HWRITE=%b LOCK=%b HADDR=%h, want 10 0 1 00004000", HTRANS, HWRITE, HMASTLOCK, HADDR);
    end
    tick();
    checks++;
    if ({HTRANS, HMASTLOCK} !== {2'b00, 1'b1}) begin
      errors++; $display("FAIL swp_rd_data: HTRANS=%b LOCK=%b, want 00 1", HTRANS, HMASTLOCK);
    end
    tick();
    HRDATA = 32'hBAD0BAD0;
    checks++;
    if ({HTRANS, HWRITE, HMASTLOCK, HADDR, wb_en} !== {2'b10, 1'b1, 1'b1, 32'h4000, 1'b0}) begin
      errors++; $display("FAIL swp_wr_addr: HTRANS=%b HWRITE=%b LOCK=%b HADDR=%h wb_en=%b, want 10 1 1 00004000 0",
        HTRANS, HWRITE, HMASTLOCK, HADDR, wb_en);
    end
    tick();
    checks++;
    if ({HTRANS, HMASTLOCK, HWDATA, wb_en} !== {2'b00, 1'b1, 32'h22, 1'b0}) begin
      errors++; $display("FAIL swp_wr_data: HTRANS=%b LOCK=%b HWDATA=%h wb_en=%b, want 00 1 00000022 0", HTRANS, HMASTLOCK, HWDATA, wb_en);
    end
    tick();
    checks++;
    if ({wb_en, wb_id, wb_data, HMASTLOCK, req_ready} !== {1'b1, 5'd9, 32'h11, 1'b0, 1'b1}) begin
      errors++; $display("FAIL swp_wb: wb_en=%b id=%0d data=%h LOCK=%b ready=%b, want 1 9 00000011 0 1",
        wb_en, wb_id, wb_data, HMASTLOCK, req_ready);
    end
    tick();
  endtask

  task automatic test_error(input logic swp);
    logic saw_nonseq = 1'b0;
    logic saw_wb = 1'b0;
    issue(swp, 1'b1, 2'b00, 1'b1, 1'b0, 32'h5000, 32'h0, 32'h33, 5'd2);
    tick();
    HREADY = 1'b0; HRESP = 1'b1;
    checks++;
    if (HTRANS !== 2'b00) begin
      errors++; $display("FAIL err_c1 swp=%b: HTRANS=%b, want 00", swp, HTRANS);
    end
    tick();
    HREADY = 1'b1;
    saw_wb |= wb_en;
    tick();
    HRESP = 1'b0;
    checks++;
    if ({data_abort, wb_en, req_ready, HMASTLOCK, HTRANS} !== {1'b1, 1'b0, 1'b1, 1'b0, 2'b00}) begin
      errors++; $display("FAIL err_abort swp=%b: abort=%b wb_en=%b ready=%b LOCK=%b HTRANS=%b, want 1 0 1 0 00",
        swp, data_abort, wb_en, req_ready, HMASTLOCK, HTRANS);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      saw_nonseq |= (HTRANS == 2'b10);
      saw_wb |= wb_en;
      if (c == 0) begin
        checks++;
        if (data_abort !== 1'b0) begin
          errors++; $display("FAIL err_pulse swp=%b: data_abort=%b, want 0", swp, data_abort);
        end
      end
    end
    checks++;
    if ({saw_nonseq, saw_wb} !== 2'b00) begin
      errors++; $display("FAIL err_quiet swp=%b: nonseq=%b wb=%b after error, want 0 0", swp, saw_nonseq, saw_wb);
    end
  endtask

  task automatic test_align_and_reset();
    issue(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h1001, 32'h0, 32'h0, 5'd5);
    checks++;
    if ({align_fault, HTRANS, req_ready} !== {1'b1, 2'b00, 1'b1}) begin
      errors++; $display("FAIL align_word: afault=%b HTRANS=%b ready=%b, want 1 00 1", align_fault, HTRANS, req_ready);
    end
    tick();
    checks++;
    if ({align_fault, HTRANS} !== {1'b0, 2'b00}) begin
      errors++; $display("FAIL align_pulse: afault=%b HTRANS=%b, want 0 00", align_fault, HTRANS);
    end
    issue(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0, 32'h3001, 32'h0, 5'd5);
    checks++;
    if ({align_fault, HTRANS} !== {1'b1, 2'b00}) begin
      errors++; $display("FAIL align_half: afault=%b HTRANS=%b, want 1 00", align_fault, HTRANS);
    end
    // load stalled in DATA, then reset
    HRDATA = 32'hCAFEF00D;
    issue(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h7000, 32'h0, 32'h0, 5'd4);
    tick();
    HREADY = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if ({HTRANS, HMASTLOCK, HWRITE, HSIZE, wb_en, wb_id, req_ready, HADDR, HWDATA, wb_data} !==
        {2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 5'd0, 1'b1, 32'h0, 32'h0, 32'h0}) begin
      errors++; $display("FAIL mid_reset: HTRANS=%b LOCK=%b HWRITE=%b HSIZE=%b wb_en=%b id=%0d ready=%b HADDR=%h HWDATA=%h wb_data=%h",
        HTRANS, HMASTLOCK, HWRITE, HSIZE, wb_en, wb_id, req_ready, HADDR, HWDATA, wb_data);
    end
    rst = 1'b0;
    HREADY = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({wb_en, HTRANS} !== {1'b0, 2'b00}) begin
        errors++; $display("FAIL post_reset c=%0d: wb_en=%b HTRANS=%b, want 0 00", c, wb_en, HTRANS);
      end
    end
  endtask

  task automatic test_nop();
    issue(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h1001, 32'h0, 32'h0, 5'd1);
    checks++;
    if ({req_ready, HTRANS, align_fault} !== {1'b1, 2'b00, 1'b0}) begin
      errors++; $display("FAIL nop: ready=%b HTRANS=%b afault=%b, want 1 00 0", req_ready, HTRANS, align_fault);
    end
  endtask

  task automatic test_back_to_back();
    HRDATA = 32'h8001_1234;
    issue(1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 32'h8002, 32'h0, 32'h0, 5'd10);
    tick(); tick();
    checks++;
    if ({wb_en, wb_id, wb_data, req_ready} !== {1'b1, 5'd10, 32'hFFFF8001, 1'b1}) begin
      errors++; $display("FAIL b2b_first: wb_en=%b id=%0d data=%h ready=%b, want 1 10 ffff8001 1", wb_en, wb_id, wb_data, req_ready);
    end
    issue(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0, 32'h8000, 32'h0, 5'd11);
    checks++;
    if ({HTRANS, HSIZE, HADDR} !== {2'b10, 3'b001, 32'h8000}) begin
      errors++; $display("FAIL b2b_addr: HTRANS=%b HSIZE=%b HADDR=%h, want 10 001 00008000", HTRANS, HSIZE, HADDR);
    end
    tick(); tick();
    checks++;
    if ({wb_en, wb_id, wb_data} !== {1'b1, 5'd11, 32'h00001234}) begin
      errors++; $display("FAIL b2b_second: wb_en=%b id=%0d data=%h, want 1 11 00001234", wb_en, wb_id, wb_data);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_ldr_word();
    test_ldrb_ext();
    test_strh_wait();
    test_swp();
    test_error(1'b0);
    test_error(1'b1);
    test_align_and_reset();
    test_nop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
